// File: rtl/div_pkg.sv
// div_pkg: shared width default, FSM encoding and divide-by-zero quotient for the divider
package div_pkg;
   localparam int DIV_N = 8;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
   localparam logic [2*DIV_N-1:0] DZ_QUOT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration (shift in a dividend bit, trial subtract)
module div_step
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic [N-1:0]   i_r,
   input  logic [2*N-1:0] i_q,
   input  logic [N-1:0]   i_div,
   output logic [N-1:0]   o_r,
   output logic [2*N-1:0] o_q
);
   logic [N:0] w_sh;
   logic       w_ge;
   // widen the remainder by the shifted-in bit, subtract when it fits; the result always fits in N bits
   always_comb begin
      w_sh = {i_r, i_q[2*N-1]};
      w_ge = w_sh >= {1'b0, i_div};
      o_r  = w_sh[N-1:0] - (w_ge ? i_div : '0);
      o_q  = {i_q[2*N-2:0], w_ge};
   end
endmodule

// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock
module seq_div
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic           CLK,
   input  logic           reset,
   input  logic           in_valid,
   input  logic [2*N-1:0] in_dividend,
   input  logic [N-1:0]   in_divisor,
   output logic           busy,
   output logic [2*N-1:0] out_q,
   output logic [N-1:0]   out_r,
   output logic           out_dz,
   output logic           out_valid
);
   localparam int CW = $clog2(2*N) + 1;
   localparam logic [CW-1:0] LAST = CW'(2*N - 1);
   state_t         r_state, w_next, w_start;
   logic [N-1:0]   r_r, r_div, w_r_nxt;
   logic [2*N-1:0] r_q, w_q_nxt;
   logic [CW-1:0]  r_cnt;
   logic           r_dz_pend, w_accept, w_last;
   assign w_accept = in_valid & ~busy;
   assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);
   assign w_start  = (in_divisor == '0) ? S_DONE : S_RUN;
   div_step #(.N(N)) u_step (
      .i_r   (r_r),
      .i_q   (r_q),
      .i_div (r_div),
      .o_r   (w_r_nxt),
      .o_q   (w_q_nxt)
   );
   // state register
   always_ff @(posedge CLK or posedge reset)
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   // next state: a divide-by-zero accept parks in DONE with a pending result for one cycle
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = w_accept ? w_start : S_IDLE;
         S_RUN:   w_next = w_last ? S_DONE : S_RUN;
         S_DONE:  w_next = r_dz_pend ? S_DONE : (w_accept ? w_start : S_IDLE);
         default: w_next = S_IDLE;
      endcase
   end
   // handshake outputs: DONE is not busy so a new request can start in the result cycle
   always_comb begin
      busy      = (r_state == S_RUN) | r_dz_pend;
      out_valid = (r_state == S_DONE) & ~r_dz_pend;
   end
   // working registers: load operands on accept, iterate while running
   always_ff @(posedge CLK or posedge reset)
      if (reset) begin
         r_r       <= '0;
         r_q       <= '0;
         r_div     <= '0;
         r_cnt     <= '0;
         r_dz_pend <= 1'b0;
      end else if (w_accept) begin
         r_r       <= '0;
         r_q       <= in_dividend;
         r_div     <= in_divisor;
         r_cnt     <= '0;
         r_dz_pend <= (in_divisor == '0);
      end else if (r_state == S_RUN) begin
         r_r   <= w_r_nxt;
         r_q   <= w_q_nxt;
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_dz_pend <= 1'b0;
      end
   // result registers: hold until the next result, taken from the final iteration or the zero-divisor path
   always_ff @(posedge CLK or posedge reset)
      if (reset) begin
         out_q  <= '0;
         out_r  <= '0;
         out_dz <= 1'b0;
      end else if (w_last) begin
         out_q  <= w_q_nxt;
         out_r  <= w_r_nxt;
         out_dz <= 1'b0;
      end else if (r_dz_pend) begin
         out_q  <= '1;
         out_r  <= '0;
         out_dz <= 1'b1;
      end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized scoreboard bench for seq_div against an arithmetic reference model
module tb_seq_div;
   localparam int N = 8;
   typedef struct {
      logic [2*N-1:0] q;
      logic [N-1:0]   r;
      logic           dz;
      int             ld;
   } exp_t;
   logic           CLK = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic [2*N-1:0] in_dividend = '0;
   logic [N-1:0]   in_divisor = '0;
   logic           busy, out_dz, out_valid;
   logic [2*N-1:0] out_q;
   logic [N-1:0]   out_r;
   exp_t sb[$];
   int errs = 0, checks = 0, edge_n = 0, free_e = 0, acc_cnt = 0;

   seq_div #(.N(N)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_dividend (in_dividend),
      .in_divisor  (in_divisor),
      .busy        (busy),
      .out_q       (out_q),
      .out_r       (out_r),
      .out_dz      (out_dz),
      .out_valid   (out_valid)
   );

   initial forever #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, req, edge_n);
      end
   endtask

   // reference model: a request is taken whenever the divider is free; result = plain / and %
   always @(posedge CLK) begin
      exp_t e;
      edge_n++;
      if (reset) begin
         sb.delete();
         free_e = 0;
      end else if (in_valid && edge_n >= free_e) begin
         if (in_divisor == 0) begin
            e.q = '1; e.r = '0; e.dz = 1'b1; e.ld = edge_n + 1; free_e = edge_n + 2;
         end else begin
            e.q = in_dividend / in_divisor;
            e.r = N'(in_dividend % in_divisor);
            e.dz = 1'b0; e.ld = edge_n + 2*N; free_e = edge_n + 2*N + 1;
         end
         sb.push_back(e);
         acc_cnt++;
      end
   end

   // monitor: busy every cycle, results whenever out_valid is presented
   always @(negedge CLK) begin
      exp_t e;
      chk("busy", {31'd0, busy}, {31'd0, !reset && (edge_n < free_e - 1)});
      if (out_valid) begin
         if (sb.size() == 0) chk("spurious_valid", {31'd0, out_valid}, 0);
         else begin
            e = sb.pop_front();
            chk("out_q", out_q, e.q);
            chk("out_r", out_r, e.r);
            chk("out_dz", out_dz, e.dz);
            chk("latency", edge_n, e.ld);
         end
      end else if (sb.size() > 0 && sb[0].ld <= edge_n) begin
         chk("valid_missing", {31'd0, out_valid}, 1);
         void'(sb.pop_front());
      end
   end

   task automatic wait_acc(input int n);
      int t = 0;
      while (acc_cnt == n && t < 200) begin
         @(posedge CLK); #1; t++;
      end
   endtask

   task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b);
      int n = acc_cnt;
      in_dividend = a; in_divisor = b; in_valid = 1'b1;
      wait_acc(n);
      in_valid = 1'b0;
      in_dividend = 16'($urandom); in_divisor = 8'($urandom);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() > 0 && t < 100) begin
         @(negedge CLK); t++;
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_q"}, out_q, 0);
      chk({nm, "_r"}, out_r, 0);
      chk({nm, "_dz"}, {31'd0, out_dz}, 0);
      chk({nm, "_valid"}, {31'd0, out_valid}, 0);
      chk({nm, "_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      int n, k;
      repeat (2) @(posedge CLK);
      #1;
      chk_zero("reset");
      reset = 1'b0;
      issue(27, 9);     issue(1000, 7);  issue(65535, 255); issue(65535, 1);
      issue(5, 9);      issue(0, 3);     issue(3, 0);       issue(861, 7);
      issue(660, 60);   issue(140, 14);  issue(3, 0);       issue(3, 0);
      drain();
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n = acc_cnt;
         in_dividend = 16'($urandom);
         in_divisor = 8'($urandom_range(1, 255));
         wait_acc(n);
         in_dividend = 16'($urandom);
         in_divisor = 8'($urandom_range(0, 255));
         repeat (3) @(posedge CLK);
         #1;
      end
      in_valid = 1'b0;
      drain();
      issue(1000, 7);
      repeat (7) @(posedge CLK);
      #1;
      reset = 1'b1;
      #1;
      chk_zero("midreset");
      @(posedge CLK);
      #1;
      reset = 1'b0;
      issue(861, 7);
      drain();
      for (int i = 0; i < 40; i++) begin
         k = int'($urandom_range(0, 9));
         issue(k < 2 ? 16'($urandom_range(0, 300)) : 16'($urandom),
               k == 0 ? 8'd0 : (k < 4 ? 8'($urandom_range(1, 15)) : 8'($urandom_range(1, 255))));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge CLK);
         #1;
      end
      drain();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
